// File: rtl/act_feed_scheduler_if.sv
// Handshake/bus bundle between the activation feed scheduler and its
// neighbours: weight-load controller (start), activation memory read lanes,
// compensation-row table and the compensation request consumer.
interface act_feed_scheduler_if #(
  parameter int SIZE = 8
);
  localparam int ADDR_W = $clog2(SIZE*SIZE);
  localparam int CIDX_W = $clog2(3*SIZE);
  localparam int CROW_W = SIZE/2 + 1;
  localparam int COL_W  = $clog2(SIZE);

  logic                   start;
  logic                   hold;
  logic [SIZE-1:0]        act_rd_en;
  logic [SIZE*ADDR_W-1:0] act_rd_addr;
  logic [CIDX_W-1:0]      comp_idx;
  logic [CROW_W-1:0]      comp_entry;
  logic                   comp_valid;
  logic [COL_W-1:0]       comp_col;
  logic [CROW_W-2:0]      comp_row;
  logic                   comp_ready;
  logic                   busy;
  logic                   done;

  modport master (
    input  start, hold, comp_entry, comp_ready,
    output act_rd_en, act_rd_addr, comp_idx, comp_valid, comp_col, comp_row,
           busy, done
  );

  modport slave (
    output start, hold, comp_entry, comp_ready,
    input  act_rd_en, act_rd_addr, comp_idx, comp_valid, comp_col, comp_row,
           busy, done
  );
endinterface

// File: rtl/act_feed_scheduler.sv
// Activation feed scheduler: after weight loading, streams the activation
// memory into the systolic array with diagonal skew (FEED), then walks the
// compensation-row table issuing one request per valid entry (COMP).
//
// Optional build macro: COMP_COL_SKIP_EN -- an empty table entry jumps the
// index straight to the next 3-entry column group instead of stepping by 1.
//
//   state | meaning
//   IDLE  | waiting for start pulse
//   FEED  | skewed activation reads, counter t = 0 .. 2*SIZE-2
//   COMP  | compensation table walk, index 0 .. 3*SIZE-1
//   FIN   | one-cycle done pulse, then back to IDLE
module act_feed_scheduler #(
  parameter int SIZE = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  act_feed_scheduler_if.master  bus
);
  localparam int ADDR_W = $clog2(SIZE*SIZE);
  localparam int CIDX_W = $clog2(3*SIZE);
  localparam int CROW_W = SIZE/2 + 1;
  localparam int COL_W  = $clog2(SIZE);
  localparam int T_W    = $clog2(2*SIZE - 1);

  localparam logic [T_W-1:0]    T_LAST    = T_W'(2*SIZE - 2);
  localparam logic [CROW_W-1:0] ENTRY_NIL = CROW_W'(SIZE);
  localparam logic [CIDX_W:0]   IDX_END   = (CIDX_W+1)'(3*SIZE);

  typedef enum logic [1:0] {IDLE, FEED, COMP, FIN} state_t;

  state_t                 state, state_nxt;
  logic [T_W-1:0]         t_q, t_nxt;
  logic [CIDX_W-1:0]      idx_q, idx_nxt;
  logic [SIZE-1:0]        en_q, en_nxt;
  logic [SIZE*ADDR_W-1:0] addr_q, addr_nxt;
  logic                   valid_q, valid_nxt;
  logic                   busy_q, busy_nxt;
  logic                   done_q, done_nxt;

  logic                   entry_nil;
  logic                   feed_step;
  logic                   feed_last;
  logic                   comp_adv;
  logic                   comp_last;
  logic [CIDX_W:0]        idx_step;

  assign entry_nil = (bus.comp_entry == ENTRY_NIL);
  assign feed_step = (state == FEED) && !bus.hold;
  assign feed_last = feed_step && (t_q == T_LAST);
  // A pending request moves on only when accepted; an empty slot moves on at once.
  assign comp_adv  = (state == COMP) && (valid_q ? bus.comp_ready : entry_nil);
  assign comp_last = (idx_step >= IDX_END);

  // Index the table walk moves to when it advances (one extra bit to see the end).
  always_comb begin
    idx_step = {1'b0, idx_q} + (CIDX_W+1)'(1);
`ifdef COMP_COL_SKIP_EN
    if (!valid_q)
      idx_step = {1'b0, idx_q} - ({1'b0, idx_q} % (CIDX_W+1)'(3)) + (CIDX_W+1)'(3);
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = FEED;
      FEED: if (feed_last) state_nxt = COMP;
      COMP: if (comp_adv && comp_last) state_nxt = FIN;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the counters and registered outputs.
  always_comb begin
    t_nxt     = t_q;
    idx_nxt   = idx_q;
    en_nxt    = '0;
    addr_nxt  = addr_q;
    valid_nxt = 1'b0;
    busy_nxt  = (state_nxt != IDLE);
    done_nxt  = (state_nxt == FIN);
    case (state)
      IDLE: begin
        t_nxt = '0;
      end
      FEED: begin
        if (feed_step) begin
          // Lane r sees vector (t-r), element r: the diagonal wavefront.
          for (int r = 0; r < SIZE; r++) begin
            if ((int'(t_q) >= r) && (int'(t_q) - r <= SIZE - 1)) begin
              en_nxt[r] = 1'b1;
              addr_nxt[r*ADDR_W +: ADDR_W] = ADDR_W'((int'(t_q) - r) * SIZE + r);
            end
          end
          if (feed_last) begin
            t_nxt   = '0;
            idx_nxt = '0;
          end else begin
            t_nxt = t_q + T_W'(1);
          end
        end
      end
      COMP: begin
        if (comp_adv) begin
          // The index parks on the last slot rather than wrapping.
          if (!comp_last) idx_nxt = idx_step[CIDX_W-1:0];
        end else if (valid_q || !entry_nil) begin
          valid_nxt = 1'b1;
        end
      end
      FIN: begin
        t_nxt = '0;
      end
      default: begin
        t_nxt = '0;
      end
    endcase
  end

  // Counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_q     <= '0;
      idx_q   <= '0;
      en_q    <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      t_q     <= t_nxt;
      idx_q   <= idx_nxt;
      en_q    <= en_nxt;
      addr_q  <= addr_nxt;
      valid_q <= valid_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
    end
  end

  assign bus.act_rd_en   = en_q;
  assign bus.act_rd_addr = addr_q;
  assign bus.comp_idx    = idx_q;
  assign bus.comp_valid  = valid_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.comp_col    = COL_W'(idx_q / CIDX_W'(3));
  assign bus.comp_row    = bus.comp_entry[CROW_W-2:0];
endmodule

// File: tb/tb_act_feed_scheduler.sv
// Scoreboard bench for act_feed_scheduler (default build, SIZE=8).
module tb_act_feed_scheduler;
  localparam int SIZE   = 8;
  localparam int ADDR_W = 6;
  localparam int CROW_W = 5;
  localparam int NTAB   = 24;

  typedef struct packed {
    logic [SIZE-1:0]        en;
    logic [SIZE*ADDR_W-1:0] addr;
  } feed_t;

  typedef struct packed {
    logic [2:0] col;
    logic [3:0] row;
  } cmp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  act_feed_scheduler_if #(.SIZE(SIZE)) bus ();
  act_feed_scheduler #(.SIZE(SIZE)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [CROW_W-1:0] tab [NTAB];
  assign bus.comp_entry = tab[bus.comp_idx];

  feed_t fq[$];
  cmp_t  cq[$];
  feed_t fe;
  cmp_t  ce;
  int    checks = 0;
  int    errors = 0;
  int    cyc;
  logic [SIZE*ADDR_W-1:0] addr_save;
  logic  lane_bad;

  task automatic chk(input string name, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  function automatic feed_t feed_vec(input int t);
    feed_t v;
    v = '0;
    for (int r = 0; r < SIZE; r++) begin
      if (r <= t && t - r <= SIZE - 1) begin
        v.en[r] = 1'b1;
        v.addr[r*ADDR_W +: ADDR_W] = ADDR_W'((t - r) * SIZE + r);
      end
    end
    return v;
  endfunction

  // Monitor: pops expectations whenever the DUT presents a read or a request.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.act_rd_en != '0) begin
        checks++;
        if (fq.size() == 0) begin
          errors++;
          $display("FAIL feed_unexpected: got en=0x%0h required no read", bus.act_rd_en);
        end else begin
          fe = fq.pop_front();
          lane_bad = 1'b0;
          for (int r = 0; r < SIZE; r++)
            if (fe.en[r] && bus.act_rd_addr[r*ADDR_W +: ADDR_W] !== fe.addr[r*ADDR_W +: ADDR_W])
              lane_bad = 1'b1;
          if (bus.act_rd_en !== fe.en || lane_bad) begin
            errors++;
            $display("FAIL feed_vec: got en=0x%0h addr=0x%0h required en=0x%0h addr=0x%0h",
                     bus.act_rd_en, bus.act_rd_addr, fe.en, fe.addr);
          end
        end
      end
      if (bus.comp_valid && bus.comp_ready) begin
        checks++;
        if (cq.size() == 0) begin
          errors++;
          $display("FAIL comp_unexpected: got col=%0d row=%0d required no request",
                   bus.comp_col, bus.comp_row);
        end else begin
          ce = cq.pop_front();
          if (bus.comp_col !== ce.col || bus.comp_row !== ce.row) begin
            errors++;
            $display("FAIL comp_req: got col=%0d row=%0d required col=%0d row=%0d",
                     bus.comp_col, bus.comp_row, ce.col, ce.row);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push_feed();
    for (int t = 0; t <= 2*SIZE - 2; t++) fq.push_back(feed_vec(t));
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    cyc = 0;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_first_en();
    int n;
    n = 0;
    while (bus.act_rd_en == '0 && n < 20) begin
      tick();
      n++;
    end
    if (bus.act_rd_en == '0) begin
      errors++;
      $display("FAIL feed_timeout: got no read enable required one within 20 cycles");
    end
  endtask

  task automatic wait_done(input string name, input int exp_cyc);
    int n;
    n = 0;
    while (!bus.done && n < 200) begin
      tick();
      n++;
    end
    if (!bus.done) begin
      errors++;
      $display("FAIL %s_timeout: got no done required done within 200 cycles", name);
    end else begin
      if (exp_cyc > 0) chk({name, "_done_cycle"}, cyc, exp_cyc);
      tick();
      chk({name, "_done_width"}, 32'(bus.done), 0);
      chk({name, "_busy_drop"}, 32'(bus.busy), 0);
    end
    chk({name, "_feed_drained"}, fq.size(), 0);
    chk({name, "_comp_drained"}, cq.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.hold = 1'b0;
    bus.comp_ready = 1'b1;
    for (int i = 0; i < NTAB; i++) tab[i] = CROW_W'(8);
    cyc = 0;
    #12;
    chk("rst_en", 32'(bus.act_rd_en), 0);
    chk("rst_addr_lo", 32'(bus.act_rd_addr[31:0]), 0);
    chk("rst_addr_hi", 32'(bus.act_rd_addr[47:32]), 0);
    chk("rst_idx", 32'(bus.comp_idx), 0);
    chk("rst_valid", 32'(bus.comp_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    tick();
    rst = 1'b0;
    tick();

    // Pass 1: no hold, empty table.
    push_feed();
    do_start();
    wait_first_en();
    chk("p1_first_en", 32'(bus.act_rd_en), 32'h01);
    chk("p1_first_lane0", 32'(bus.act_rd_addr[0 +: ADDR_W]), 0);
    chk("p1_busy", 32'(bus.busy), 1);
    repeat (7) tick();
    chk("p1_t7_en", 32'(bus.act_rd_en), 32'hFF);
    chk("p1_t7_lane0", 32'(bus.act_rd_addr[0 +: ADDR_W]), 56);
    chk("p1_t7_lane7", 32'(bus.act_rd_addr[7*ADDR_W +: ADDR_W]), 7);
    repeat (7) tick();
    chk("p1_t14_en", 32'(bus.act_rd_en), 32'h80);
    chk("p1_t14_lane7", 32'(bus.act_rd_addr[7*ADDR_W +: ADDR_W]), 63);
    tick();
    chk("p1_feed_end", 32'(bus.act_rd_en), 0);
    wait_done("p1", 40);

    // Pass 2: hold for three cycles just before t=5 issues.
    push_feed();
    do_start();
    wait_first_en();
    repeat (4) tick();
    chk("p2_t4_en", 32'(bus.act_rd_en), 32'h1F);
    addr_save = bus.act_rd_addr;
    bus.hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("p2_hold_en", 32'(bus.act_rd_en), 0);
      chk("p2_hold_addr", 32'(bus.act_rd_addr == addr_save), 1);
    end
    bus.hold = 1'b0;
    tick();
    chk("p2_resume_t5_en", 32'(bus.act_rd_en), 32'h3F);
    chk("p2_resume_t5_lane5", 32'(bus.act_rd_addr[5*ADDR_W +: ADDR_W]), 5);
    wait_done("p2", 43);

    // Pass 3: three valid entries, consumer always ready; a stray start mid-FEED.
    tab[0] = CROW_W'(2);
    tab[1] = CROW_W'(5);
    tab[4] = CROW_W'(7);
    push_feed();
    cq.push_back('{col: 3'd0, row: 4'd2});
    cq.push_back('{col: 3'd0, row: 4'd5});
    cq.push_back('{col: 3'd1, row: 4'd7});
    do_start();
    wait_first_en();
    repeat (3) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done("p3", 0);

    // Pass 4: consumer stalls the first request for four cycles.
    bus.comp_ready = 1'b0;
    push_feed();
    cq.push_back('{col: 3'd0, row: 4'd2});
    cq.push_back('{col: 3'd0, row: 4'd5});
    cq.push_back('{col: 3'd1, row: 4'd7});
    do_start();
    begin
      int n;
      n = 0;
      while (!bus.comp_valid && n < 100) begin
        tick();
        n++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      chk("p4_stall_valid", 32'(bus.comp_valid), 1);
      chk("p4_stall_col", 32'(bus.comp_col), 0);
      chk("p4_stall_row", 32'(bus.comp_row), 2);
      chk("p4_stall_idx", 32'(bus.comp_idx), 0);
      if (k < 3) tick();
    end
    bus.comp_ready = 1'b1;
    wait_done("p4", 0);

    // Pass 5: reset while t=6 is the live counter value, then a clean restart.
    for (int i = 0; i < NTAB; i++) tab[i] = CROW_W'(8);
    push_feed();
    do_start();
    wait_first_en();
    repeat (5) tick();
    chk("p5_pre_rst_en", 32'(bus.act_rd_en), 32'h3F);
    #2;
    rst = 1'b1;
    #1;
    fq.delete();
    chk("p5_rst_en", 32'(bus.act_rd_en), 0);
    chk("p5_rst_addr", 32'(bus.act_rd_addr != '0), 0);
    chk("p5_rst_busy", 32'(bus.busy), 0);
    chk("p5_rst_done", 32'(bus.done), 0);
    chk("p5_rst_valid", 32'(bus.comp_valid), 0);
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("p5_idle_busy", 32'(bus.busy), 0);
      chk("p5_idle_done", 32'(bus.done), 0);
    end
    push_feed();
    do_start();
    wait_first_en();
    chk("p5_restart_en", 32'(bus.act_rd_en), 32'h01);
    wait_done("p5", 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
